// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Time-division demultiplexer. A serial stream carries one bit per channel
//   per slot; slot strobes arrive on en, and sync marks the slot-0 strobe.
//   Bits are collected in a shadow register and the whole frame is published
//   on ch only when its last slot has been received, so ch never shows a
//   partial frame. A three-state FSM (HUNT / FILL / LOCKED) tracks framing.
//
// Parameters
//   NCH : channels per frame (2..16)
//   CW  : slot counter width, ceil(log2(NCH))
//
// Ports
//   Clock       in   clock, all state updates on the rising edge
//   Resetn      in   asynchronous active-low reset
//   en          in   slot strobe; m and sync are sampled only when en=1
//   m           in   serial multiplexed data
//   sync        in   frame marker, high on the slot-0 strobe
//   ch          out  last complete frame, ch[i] = bit of slot i
//   frame_valid out  one-cycle pulse when ch is updated
//   frame_err   out  one-cycle pulse on a framing violation
//   locked      out  high while the FSM is in LOCKED
//   slot        out  index of the next slot expected
//
// Handshake: there is no back-pressure. A strobe (en=1) is consumed on the
// rising edge where it is seen; outputs are registered and reflect that edge
// from the following cycle on.
// ---------------------------------------------------------------------------
module tdm_demux #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           en,
  input  logic           m,
  input  logic           sync,
  output logic [NCH-1:0] ch,
  output logic           frame_valid,
  output logic           frame_err,
  output logic           locked,
  output logic [CW-1:0]  slot
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_FILL   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [CW-1:0] SLOT_ONE  = CW'(1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(NCH - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  slot_q, slot_d;
  logic [NCH-1:0] shadow_q, shadow_d;
  logic [NCH-1:0] ch_q, ch_d;
  logic           frame_valid_q, frame_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           locked_q, locked_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_d          = ch_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (en) begin
      unique case (state_q)
        S_HUNT: begin
          // Without sync the bit cannot be placed, so it is dropped.
          if (sync) begin
            shadow_d[0] = m;
            slot_d      = SLOT_ONE;
            state_d     = S_FILL;
          end
        end
        S_FILL, S_LOCKED: begin
          if (slot_q == '0) begin
            if (sync) begin
              shadow_d[0] = m;
              slot_d      = SLOT_ONE;
            end else begin
              // Expected frame start is missing: lose lock and hunt again.
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
            end
          end else if (sync) begin
            // Early sync: abandon the partial frame, restart from slot 0.
            frame_err_d = 1'b1;
            shadow_d[0] = m;
            slot_d      = SLOT_ONE;
            state_d     = S_FILL;
          end else begin
            shadow_d[slot_q] = m;
            if (slot_q == SLOT_LAST) begin
              // Publish the frame with the just-sampled bit in the top slot.
              ch_d          = shadow_q;
              ch_d[NCH-1]   = m;
              slot_d        = '0;
              frame_valid_d = 1'b1;
              state_d       = S_LOCKED;
            end else begin
              slot_d = slot_q + SLOT_ONE;
            end
          end
        end
        default: begin
          state_d = S_HUNT;
          slot_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= S_HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      ch_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_q          <= ch_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      locked_q      <= locked_d;
    end
  end

  assign ch          = ch_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign locked      = locked_q;
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int CW  = 2;

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           rst_n;
  logic           en;
  logic           m;
  logic           sync;
  logic [NCH-1:0] ch;
  logic           frame_valid;
  logic           frame_err;
  logic           locked;
  logic [CW-1:0]  slot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tdm_demux #(.NCH(NCH), .CW(CW)) dut (
    .Clock       (clk),
    .Resetn      (rst_n),
    .en          (en),
    .m           (m),
    .sync        (sync),
    .ch          (ch),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .locked      (locked),
    .slot        (slot)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [NCH-1:0] exp_q[$];
  logic           mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      chk("fv_fe_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          logic [NCH-1:0] e;
          e = exp_q.pop_front();
          chk("sb_frame", {28'd0, ch}, {28'd0, e});
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic           en;
    logic           sync;
    logic           m;
    logic [NCH-1:0] ch;
    logic           fv;
    logic           fe;
    logic           lk;
    logic [CW-1:0]  slot;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic s, input logic d, input logic [NCH-1:0] c,
                     input logic fv, input logic fe, input logic lk, input logic [CW-1:0] sl);
    vec_t v;
    v.en = e; v.sync = s; v.m = d; v.ch = c; v.fv = fv; v.fe = fe; v.lk = lk; v.slot = sl;
    vq.push_back(v);
  endtask

  // Drive one cycle at the falling edge, check registered outputs just after the rise.
  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    en = v.en; sync = v.sync; m = v.m;
    if (v.fv) exp_q.push_back(v.ch);
    @(posedge clk);
    #1;
    chk({name, " ch"},    {28'd0, ch},          {28'd0, v.ch});
    chk({name, " fv"},    {31'd0, frame_valid}, {31'd0, v.fv});
    chk({name, " fe"},    {31'd0, frame_err},   {31'd0, v.fe});
    chk({name, " lk"},    {31'd0, locked},      {31'd0, v.lk});
    chk({name, " slot"},  {30'd0, slot},        {30'd0, v.slot});
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; m = 1'b0;

    // basic frame 1,0,1,1
    add(1,1,1, 4'h0, 0,0,0, 2'd1);
    add(1,0,0, 4'h0, 0,0,0, 2'd2);
    add(1,0,1, 4'h0, 0,0,0, 2'd3);
    add(1,0,1, 4'hD, 1,0,1, 2'd0);
    // back-to-back 1,1,0,0 then 0,1,1,0
    add(1,1,1, 4'hD, 0,0,1, 2'd1);
    add(1,0,1, 4'hD, 0,0,1, 2'd2);
    add(1,0,0, 4'hD, 0,0,1, 2'd3);
    add(1,0,0, 4'h3, 1,0,1, 2'd0);
    add(1,1,0, 4'h3, 0,0,1, 2'd1);
    add(1,0,1, 4'h3, 0,0,1, 2'd2);
    add(1,0,1, 4'h3, 0,0,1, 2'd3);
    add(1,0,0, 4'h6, 1,0,1, 2'd0);
    // en toggling, frame 0,1,0,1; idle cycles carry junk that must be ignored
    add(1,1,0, 4'h6, 0,0,1, 2'd1);
    add(0,1,1, 4'h6, 0,0,1, 2'd1);
    add(1,0,1, 4'h6, 0,0,1, 2'd2);
    add(0,1,0, 4'h6, 0,0,1, 2'd2);
    add(1,0,0, 4'h6, 0,0,1, 2'd3);
    add(0,0,1, 4'h6, 0,0,1, 2'd3);
    add(1,0,1, 4'hA, 1,0,1, 2'd0);
    add(0,0,0, 4'hA, 0,0,1, 2'd0);
    // missing sync while locked, then HUNT discards unsynced bits
    add(1,0,1, 4'hA, 0,1,0, 2'd0);
    add(1,0,1, 4'hA, 0,0,0, 2'd0);
    // 1,0 then early sync on slot 2 followed by 1,1,1,1
    add(1,1,1, 4'hA, 0,0,0, 2'd1);
    add(1,0,0, 4'hA, 0,0,0, 2'd2);
    add(1,1,1, 4'hA, 0,1,0, 2'd1);
    add(1,0,1, 4'hA, 0,0,0, 2'd2);
    add(1,0,1, 4'hA, 0,0,0, 2'd3);
    add(1,0,1, 4'hF, 1,0,1, 2'd0);
    // early sync from LOCKED drops lock until the next full frame (1,0,1,0)
    add(1,1,0, 4'hF, 0,0,1, 2'd1);
    add(1,1,1, 4'hF, 0,1,0, 2'd1);
    add(1,0,0, 4'hF, 0,0,0, 2'd2);
    add(1,0,1, 4'hF, 0,0,0, 2'd3);
    add(1,0,0, 4'h5, 1,0,1, 2'd0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ch",   {28'd0, ch},          32'd0);
    chk("rst fv",   {31'd0, frame_valid}, 32'd0);
    chk("rst fe",   {31'd0, frame_err},   32'd0);
    chk("rst lk",   {31'd0, locked},      32'd0);
    chk("rst slot", {30'd0, slot},        32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("row%0d", i), vq[i]);
    end

    // asynchronous reset between edges, mid-frame
    @(negedge clk);
    en = 1'b1; sync = 1'b1; m = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst slot", {30'd0, slot}, 32'd1);
    en = 1'b1; sync = 1'b0; m = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async ch",   {28'd0, ch},          32'd0);
    chk("async fv",   {31'd0, frame_valid}, 32'd0);
    chk("async fe",   {31'd0, frame_err},   32'd0);
    chk("async lk",   {31'd0, locked},      32'd0);
    chk("async slot", {30'd0, slot},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // unsynced data after reset must stay in HUNT
    for (int i = 0; i < 5; i++) begin
      v.en = 1'b1; v.sync = 1'b0; v.m = 1'($urandom_range(0, 1));
      v.ch = 4'h0; v.fv = 1'b0; v.fe = 1'b0; v.lk = 1'b0; v.slot = 2'd0;
      step($sformatf("hunt%0d", i), v);
    end

    // random full frame after sync, with random idle strobes interleaved
    begin
      logic [NCH-1:0] bits;
      logic [NCH-1:0] prev;
      bits = NCH'($urandom_range(0, 15));
      prev = 4'h0;
      for (int s = 0; s < NCH; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          v.en = 1'b0; v.sync = 1'b0; v.m = 1'b1;
          v.ch = prev; v.fv = 1'b0; v.fe = 1'b0; v.lk = 1'b0; v.slot = CW'(s);
          step($sformatf("idle%0d", s), v);
        end
        v.en = 1'b1; v.sync = (s == 0); v.m = bits[s];
        v.fv = (s == NCH - 1);
        v.ch = v.fv ? bits : prev;
        v.fe = 1'b0; v.lk = v.fv;
        v.slot = (s == NCH - 1) ? 2'd0 : CW'(s + 1);
        step($sformatf("rnd%0d", s), v);
      end
    end

    @(negedge clk);
    en = 1'b0; sync = 1'b0; m = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The module SHALL have parameter NCH, default 4, meaning the number of time-division channels per frame; legal range is 2..16.
REQ-002 The module SHALL have parameter CW, default 2, meaning the slot counter width; it equals ceil(log2(NCH)).
REQ-003 Port Clock SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port Resetn SHALL be: input, 1 bit, reset, asynchronous and active-low.
REQ-005 Port en SHALL be: input, 1 bit, slot strobe; m and sync are sampled only on edges where en=1.
REQ-006 Port m SHALL be: input, 1 bit, serial multiplexed data, one channel bit per slot.
REQ-007 Port sync SHALL be: input, 1 bit, frame marker, high only during the slot-0 strobe.
REQ-008 Port ch SHALL be: output, NCH bits, last complete frame; ch[i] = bit received in slot i.
REQ-009 Port frame_valid SHALL be: output, 1 bit, one-cycle pulse when ch is updated.
REQ-010 Port frame_err SHALL be: output, 1 bit, one-cycle pulse on a framing violation.
REQ-011 Port locked SHALL be: output, 1 bit, high while the state is LOCKED.
REQ-012 Port slot SHALL be: output, CW bits, index of the next slot expected.

Function
REQ-013 The FSM SHALL have exactly three states: HUNT, FILL and LOCKED; FILL means the first frame is in progress after HUNT or after a resync.
REQ-014 On an edge with en=0, all state, counter, shadow register and ch SHALL hold, and frame_valid and frame_err SHALL be 0.
REQ-015 In HUNT, an edge with en=1 and sync=0 SHALL discard m and leave the state in HUNT.
REQ-016 In HUNT, an edge with en=1 and sync=1 SHALL store m in shadow[0], set slot to 1, and move to FILL.
REQ-017 In FILL or LOCKED, when en=1, slot!=0 and sync=0, m SHALL be stored in shadow[slot] and slot SHALL be incremented.
REQ-018 On the edge that samples slot NCH-1, ch SHALL be loaded with {m, shadow[NCH-2:0]}, slot SHALL wrap to 0, frame_valid SHALL pulse, and the state SHALL become LOCKED.
REQ-019 The latency SHALL be 1 clock: ch and frame_valid are visible in the cycle after the edge that samples the last bit.
REQ-020 In FILL or LOCKED, when en=1, slot=0 and sync=1, m SHALL be stored in shadow[0] and slot SHALL become 1 (normal frame start).
REQ-021 In FILL or LOCKED, when en=1, slot=0 and sync=0 (missing sync), frame_err SHALL pulse and the state SHALL go to HUNT; ch is held and no frame_valid occurs.
REQ-022 In FILL or LOCKED, when en=1, slot!=0 and sync=1 (early sync), frame_err SHALL pulse, the partial frame SHALL be discarded, m SHALL be stored in shadow[0], slot SHALL become 1, and the state SHALL become FILL.
REQ-023 After an early sync (REQ-022), locked SHALL drop until the next complete frame.
REQ-024 ch SHALL change only on frame completion; a partial frame SHALL never be visible on ch.
REQ-025 frame_valid and frame_err SHALL never both be high in the same cycle.
REQ-026 slot SHALL never exceed NCH-1, including when NCH is not a power of two.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 Resetn=0 SHALL immediately, without waiting for Clock, force: state HUNT, slot=0, shadow=0, ch=0, frame_valid=0, frame_err=0, locked=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait in HUNT for sync.
REQ-030 Reset deassertion SHALL take effect on the next rising Clock edge.

Verification
REQ-031 With NCH=4 and en=1 every cycle, a frame with sync on slot 0 and m=1,0,1,1 for slots 0..3 SHALL produce ch=4'b1101, frame_valid high for 1 cycle, and locked=1.
REQ-032 Two back-to-back frames, 1,1,0,0 then 0,1,1,0, SHALL produce ch=4'b0011 then ch=4'b0110, with frame_valid pulses 4 cycles apart.
REQ-033 With en toggling 1,0,1,0,... across a frame of 0,1,0,1, the result SHALL be ch=4'b1010, and the frame SHALL complete after 4 strobes, not 4 clocks.
REQ-034 When LOCKED with sync=0 on slot 0, frame_err SHALL pulse, locked=0, the state SHALL be HUNT, and ch SHALL retain its prior value.
REQ-035 An early sync on slot 2 of frame 1,0,x followed by 1,1,1,1 SHALL produce one frame_err pulse, then ch=4'b1111 with frame_valid.
REQ-036 Resetn pulsed low between Clock edges mid-frame SHALL clear all outputs to 0 immediately, and no frame_valid SHALL occur until a full frame follows a sync.
